// File: rtl/aes_inv_mix_columns_if.sv
// Handshake bundle for the InvMixColumns engine: one 128-bit input channel
// and one 128-bit output channel, each with its own valid/ready pair.
// The slave modport is the engine's view; the master modport is the
// producer/consumer side that feeds and drains it.
interface aes_inv_mix_columns_if;
  logic         IN_VALID;
  logic         IN_READY;
  logic [127:0] IN;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [127:0] OUT;

  modport master (
    output IN_VALID,
    output IN,
    output OUT_READY,
    input  IN_READY,
    input  OUT_VALID,
    input  OUT
  );

  modport slave (
    input  IN_VALID,
    input  IN,
    input  OUT_READY,
    output IN_READY,
    output OUT_VALID,
    output OUT
  );
endinterface

// File: rtl/aes_inv_mix_columns.sv
// AES InvMixColumns engine. One 128-bit state is accepted, each column is
// multiplied by the inverse MixColumns matrix over GF(2^8) mod 0x11B,
// COLS_PER_CYCLE columns per clock, and the result is offered downstream.
// Byte b of a state sits at bits [127-8b -: 8], b = 4*row + col, so
// column c is made of bytes c, c+4, c+8, c+12.
module aes_inv_mix_columns #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                        CLOCK,
  input  logic                        RESET,
  aes_inv_mix_columns_if.slave        bus,
  output logic                        BUSY
);

  // Only widths that divide the four columns evenly are meaningful.
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_inv_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Counter step and the counter value at which the final group of columns
  // is written. For four columns per cycle both truncate to 0, so the
  // counter stays at 0 and COMPUTE lasts a single cycle.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  state_e       state_q;
  state_e       state_d;
  logic [1:0]   col_q;
  logic [127:0] src_q;
  logic [127:0] res_q;
  logic [127:0] res_d;
  logic         accept;

  // ---------------------------------------------------------------------
  // GF(2^8) helpers
  // ---------------------------------------------------------------------

  // Multiply by x (0x02), reducing by 0x11B when bit 7 falls off.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse MixColumns on one column {s0,s1,s2,s3} (s0 in the top byte).
  // The constants 09/0b/0d/0e are built from x, x^2 and x^3 multiples.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] s);
    logic [7:0] a  [4];
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = s[31 - 8*i -: 8];
      x1[i] = xtime(a[i]);
      x2[i] = xtime(x1[i]);
      x3[i] = xtime(x2[i]);
      m9[i] = x3[i] ^ a[i];
      mb[i] = x3[i] ^ x1[i] ^ a[i];
      md[i] = x3[i] ^ x2[i] ^ a[i];
      me[i] = x3[i] ^ x2[i] ^ x1[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Gather column c of a state, row 0 in the top byte.
  function automatic logic [31:0] get_col(input logic [127:0] v, input logic [1:0] c);
    logic [31:0] col;
    col = '0;
    for (int r = 0; r < 4; r++) begin
      col[31 - 8*r -: 8] = v[127 - 8*(4*r + int'(c)) -: 8];
    end
    return col;
  endfunction

  // Scatter a column back into column c of a state.
  function automatic logic [127:0] put_col(input logic [127:0] v, input logic [1:0] c,
                                           input logic [31:0] col);
    logic [127:0] res;
    res = v;
    for (int r = 0; r < 4; r++) begin
      res[127 - 8*(4*r + int'(c)) -: 8] = col[31 - 8*r -: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------

  assign accept = (state_q == IDLE) && bus.IN_VALID;

  // State register; RESET wins over every handshake and drops any block.
  always_ff @(posedge CLOCK) begin
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the values from before this edge.
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, run the columns, wait for the consumer.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.IN_VALID)      state_d = COMPUTE;
      COMPUTE: if (col_q == LAST_COL) state_d = DONE;
      DONE:    if (bus.OUT_READY)     state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded purely from the current state.
  always_comb begin
    bus.IN_READY  = 1'b0;
    bus.OUT_VALID = 1'b0;
    BUSY          = 1'b1;
    unique case (state_q)
      IDLE:    begin bus.IN_READY = 1'b1; BUSY = 1'b0; end
      COMPUTE: ;
      DONE:    bus.OUT_VALID = 1'b1;
      default: ;
    endcase
  end

  assign bus.OUT = res_q;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------

  // Transform the current group of columns into a copy of the result.
  always_comb begin
    res_d = res_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      res_d = put_col(res_d, col_q + 2'(j),
                      inv_mix_col(get_col(src_q, col_q + 2'(j))));
    end
  end

  // Column counter and result register; OUT keeps its value between blocks.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      col_q <= '0;
      res_q <= '0;
    end else if (accept) begin
      col_q <= '0;
    end else if (state_q == COMPUTE) begin
      col_q <= col_q + COL_STEP;
      res_q <= res_d;
    end
  end

  // Capture the incoming state on acceptance.
  always_ff @(posedge CLOCK) begin
    // NOTE: no reset here -- src_q is only read in COMPUTE, which is always
    // preceded by a capture, so its power-up contents never reach OUT.
    if (accept) begin
      src_q <= bus.IN;
    end
  end

endmodule
